// File: rtl/tx_dibit_framer.sv
// Byte-to-dibit unpacker that prepends a fixed alternating preamble to each packet
// and presents one {I,Q} symbol per output handshake to the QPSK mapper.
module tx_dibit_framer #(
    parameter int unsigned PREAMBLE_SYMS = 16,
    parameter logic [1:0]  PREAMBLE_A    = 2'b11,
    parameter logic [1:0]  PREAMBLE_B    = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_I,
    output logic       out_Q,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_SYMS - 1);

    state_t     state;
    logic [7:0] pre_cnt;
    logic [7:0] shreg;
    logic [1:0] sym_cnt;
    logic       buf_valid;
    logic       buf_last;
    logic [1:0] pre_sym;
    logic       out_hs;
    logic       in_hs;

    // Outputs are decoded from registers only; in_ready alone sees out_ready
    // so a new byte can load in the same cycle the previous one drains.
    always_comb begin
        pre_sym   = pre_cnt[0] ? PREAMBLE_B : PREAMBLE_A;
        out_valid = (state == PREAMBLE) | ((state == PAYLOAD) & buf_valid);
        out_I     = (state == PREAMBLE) ? pre_sym[1] : ((state == PAYLOAD) & buf_valid & shreg[7]);
        out_Q     = (state == PREAMBLE) ? pre_sym[0] : ((state == PAYLOAD) & buf_valid & shreg[6]);
        out_last  = (state == PAYLOAD) & buf_valid & buf_last & (sym_cnt == 2'd3);
        in_ready  = (state == PAYLOAD) &
                    (~buf_valid | (out_ready & (sym_cnt == 2'd3) & ~buf_last));
        busy      = (state != IDLE);
    end

    assign out_hs = out_valid & out_ready;
    assign in_hs  = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= 8'd0;
            shreg     <= 8'd0;
            sym_cnt   <= 2'd0;
            buf_valid <= 1'b0;
            buf_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= (PREAMBLE_SYMS == 0) ? PAYLOAD : PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (out_ready) begin
                        if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= 8'd0;
                            state   <= PAYLOAD;
                        end else begin
                            pre_cnt <= pre_cnt + 8'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (out_hs) begin
                        shreg   <= {shreg[5:0], 2'b00};
                        sym_cnt <= sym_cnt + 2'd1;
                        if (sym_cnt == 2'd3) begin
                            buf_valid <= 1'b0;
                            if (buf_last) begin
                                buf_last <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    // A load in the draining cycle overrides the shift above.
                    if (in_hs) begin
                        shreg     <= in_data;
                        buf_valid <= 1'b1;
                        sym_cnt   <= 2'd0;
                        buf_last  <= in_last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_dibit_framer.sv
// Bench for tx_dibit_framer: a symbol-queue model of the packet stream checked on
// every output handshake, plus directed literal checks on latency, reset and a no-preamble build.
module tb_tx_dibit_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_I, out_Q, out_valid, out_last;
    logic       out_ready = 1'b1;
    logic       busy;

    logic [7:0] z_in_data = 8'd0;
    logic       z_in_valid = 1'b0;
    logic       z_in_last = 1'b0;
    logic       z_in_ready;
    logic       z_out_I, z_out_Q, z_out_valid, z_out_last;
    logic       z_out_ready = 1'b1;
    logic       z_busy;

    always #5 clk = ~clk;

    tx_dibit_framer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_I(out_I), .out_Q(out_Q), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    tx_dibit_framer #(.PREAMBLE_SYMS(0)) dut_z (
        .clk(clk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_last(z_in_last),
        .in_ready(z_in_ready), .out_I(z_out_I), .out_Q(z_out_Q), .out_valid(z_out_valid),
        .out_last(z_out_last), .out_ready(z_out_ready), .busy(z_busy)
    );

    int checks = 0;
    int fails = 0;
    logic [2:0] exp_q[$];   // {I, Q, last} in emission order
    int hs_cnt = 0;
    int last_cnt = 0;
    int gap_cnt = 0;
    int acc_cnt = 0;
    bit rnd_mode = 1'b0;
    bit prev_stall = 1'b0;
    logic [3:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_model(input logic [7:0] b[$]);
        logic [7:0] tmp;
        for (int k = 0; k < 16; k++)
            exp_q.push_back({((k % 2) == 0) ? 2'b11 : 2'b00, 1'b0});
        for (int i = 0; i < b.size(); i++) begin
            tmp = b[i];
            for (int d = 0; d < 4; d++)
                exp_q.push_back({tmp[7-2*d -: 2], (i == b.size() - 1) && (d == 3)});
        end
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_I, out_Q, out_last}, held);
            if (!busy) begin
                check("idle_in_ready", in_ready, 1'b0);
                check("idle_out_valid", out_valid, 1'b0);
            end
            if (busy && !out_valid) gap_cnt++;
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sym", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sym", {out_I, out_Q, out_last}, e);
                end
                hs_cnt++;
                if (out_last) last_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            held = {out_valid, out_I, out_Q, out_last};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic drive_packet(input logic [7:0] b[$]);
        bit hs;
        int t;
        for (int i = 0; i < b.size(); i++) begin
            in_data  = b[i];
            in_last  = (i == b.size() - 1);
            in_valid = 1'b1;
            t = 0;
            hs = 1'b0;
            while (!hs && t < 2000) begin
                @(negedge clk);
                hs = in_valid && in_ready;
                @(posedge clk);
                t++;
            end
            if (!hs) check("in_timeout", 1'b1, 1'b0);
            #2;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b[$]);
        push_model(b);
        drive_packet(b);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 3000) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
            t++;
        end
        check("idle_reached", (t < 3000), 1'b1);
        check("model_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] pkt[$];
        logic [3:0] zexp[4];
        int base, t;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_I", out_I, 1'b0);
        check("rst_out_Q", out_Q, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #2; rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Single-byte packet 0xB4 with first-symbol latency
        pkt = {8'hB4};
        push_model(pkt);
        check("model_pre0", exp_q[0], 3'b110);
        check("model_pre1", exp_q[1], 3'b000);
        check("model_pl0", exp_q[16], 3'b100);
        check("model_pl1", exp_q[17], 3'b110);
        check("model_pl2", exp_q[18], 3'b010);
        check("model_pl3", exp_q[19], 3'b001);
        base = last_cnt;
        in_data = 8'hB4; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("lat_idle_valid", out_valid, 1'b0);
        check("lat_idle_busy", busy, 1'b0);
        @(negedge clk);
        check("lat_pre_valid", out_valid, 1'b1);
        check("lat_pre_sym", {out_I, out_Q}, 2'b11);
        check("lat_pre_in_ready", in_ready, 1'b0);
        drive_packet(pkt);
        wait_idle();
        check("t1_last_count", last_cnt - base, 1);

        // Three bytes streamed with in_valid held
        gap_cnt = 0; acc_cnt = 0;
        pkt = {8'h00, 8'hFF, 8'h5A};
        send_packet(pkt);
        wait_idle();
        check("t2_gap_cycles", gap_cnt, 1);
        check("t2_bytes_accepted", acc_cnt, 3);

        // Random backpressure
        rnd_mode = 1'b1;
        base = hs_cnt;
        pkt = {8'h3C, 8'hE1};
        send_packet(pkt);
        wait_idle();
        rnd_mode = 1'b0;
        check("t3_sym_total", hs_cnt - base, 24);

        // Two back-to-back packets
        base = last_cnt;
        pkt = {8'h12, 8'h34};
        send_packet(pkt);
        pkt = {8'h9C};
        send_packet(pkt);
        wait_idle();
        check("t4_last_count", last_cnt - base, 2);

        // No-preamble build, byte 0xC3
        zexp[0] = 4'b1110; zexp[1] = 4'b1000; zexp[2] = 4'b1000; zexp[3] = 4'b1111;
        @(posedge clk); #2;
        z_in_data = 8'hC3; z_in_last = 1'b1; z_in_valid = 1'b1;
        @(negedge clk);
        check("z_idle_in_ready", z_in_ready, 1'b0);
        check("z_idle_valid", z_out_valid, 1'b0);
        @(negedge clk);
        check("z_payload_in_ready", z_in_ready, 1'b1);
        check("z_payload_busy", z_busy, 1'b1);
        @(posedge clk); #2; z_in_valid = 1'b0; z_in_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("z_sym", {z_out_valid, z_out_I, z_out_Q, z_out_last}, zexp[k]);
        end
        @(negedge clk);
        check("z_done_busy", z_busy, 1'b0);

        // Reset while the second dibit of the byte is presented
        hs_cnt = 0;
        pkt = {8'hA5};
        push_model(pkt);
        @(posedge clk); #2;
        in_data = 8'hA5; in_last = 1'b1; in_valid = 1'b1;
        t = 0;
        while (hs_cnt < 17 && t < 200) begin
            @(posedge clk); #3;
            t++;
        end
        check("rst_wait", (hs_cnt == 17), 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #2;
        send_packet(pkt);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
